dvicmd_sched: RTL and testbench
===============================

# dvicmd_sched

Command scheduler that decides which source drives the LED-panel DVI command word (`DviCmd`). It arbitrates between three sources:
- the DVI-embedded command, accepted only after a stability filter;
- a host command port with a req/ack handshake and a hold-off timer;
- a fixed default command.

It also generates the toggling `wdt_clr` heartbeat that keeps `dot_wdt` from firing while a valid source is active. It sits between the DVI decoder/host interface and `dot_wdt`/LED driver, clocked on the 2 kHz `clkwdt` tick.

## Interface
- `CMD_W`, default 16, command word width (equals `MAX_DVICMD_BITS`).
- `STABLE_TICKS`, default 6000, consecutive identical DVI samples required before acceptance (about 3 s).
- `HOST_HOLD_TICKS`, default 20000, host ownership hold time after the last host accept (about 10 s).
- `HB_TICKS`, default 1000, maximum interval between `wdt_clr` toggles while a source is live.
- `DEFAULT_CMD`, default 0, command driven when no source owns the output.

Ports:
- `clkwdt` in 1: block clock.
- `rst` in 1: asynchronous, active-low reset.
- `dvi_cmd` in `CMD_W`: raw DVI-embedded command, sampled every clock.
- `dvi_lock` in 1: DVI link valid.
- `host_req` in 1: host request; held high until `host_ack`.
- `host_cmd` in `CMD_W`: host command; stable while `host_req` is high.
- `host_rel` in 1: single-cycle host release pulse.
- `host_ack` out 1: single-cycle acceptance pulse.
- `cmd_out` out `CMD_W`: registered active command.
- `cmd_src` out 2: owner of `cmd_out`. 0 = default, 1 = DVI, 2 = host.
- `cmd_upd` out 1: single-cycle pulse in the cycle `cmd_out` takes a new value.
- `wdt_clr` out 1: heartbeat toggle to `dot_wdt`.

## Operation
- FSM states are `S_DEF`, `S_DVI` and `S_HOST`. The state encoding equals `cmd_src`.
- DVI filter:
  - `dvi_q` holds the previous `dvi_cmd` sample. 16-bit counter `stab_cnt` counts consecutive cycles with `dvi_cmd == dvi_q`.
  - `stab_cnt` clears on mismatch or when `dvi_lock` = 0.
  - `stab_cnt` saturates at `STABLE_TICKS`.
  - `dvi_ok` = (`stab_cnt == STABLE_TICKS`) & `dvi_lock`.
- `S_DEF`:
  - `host_req` goes to `S_HOST` (host accept).
  - Otherwise `dvi_ok` goes to `S_DVI` and loads `cmd_out` = `dvi_q`.
- `S_DVI`:
  - `host_req` goes to `S_HOST`.
  - `dvi_lock` = 0 goes to `S_DEF` with `cmd_out` = `DEFAULT_CMD`.
  - `dvi_ok` & (`dvi_q != cmd_out`) reloads `cmd_out` = `dvi_q`.
- `S_HOST`:
  - `host_req` re-accepts. This loads `host_cmd` and reloads `hold_cnt` = `HOST_HOLD_TICKS`.
  - `host_rel` or `hold_cnt == 0` leaves. The exit goes to `S_DVI` with `dvi_q` if `dvi_ok`, else to `S_DEF` with `DEFAULT_CMD`.
- Host accept:
  - `cmd_out` ← `host_cmd`, `host_ack` = 1 for one cycle, `hold_cnt` ← `HOST_HOLD_TICKS`.
  - `host_req` sampled in the cycle after `host_ack` is ignored, so a req still high during handshake release does not double-accept.
- `hold_cnt` decrements by 1 per cycle in `S_HOST`. It stops at 0 and never wraps.
- `cmd_upd` = 1 only when the registered `cmd_out` value changes. Reloading an identical value gives no pulse.
- Heartbeat:
  - `hb_cnt` counts up while `cmd_src != 0`.
  - `wdt_clr` toggles on `cmd_upd` or when `hb_cnt == HB_TICKS - 1`. Either event clears `hb_cnt`.
  - In `S_DEF`, `wdt_clr` holds its value so `dot_wdt` times out.
- Simultaneous events:
  - `host_req` beats `dvi_ok`, `host_rel` and the hold timeout.
  - `host_rel` together with `host_req` is a re-accept.
  - `dvi_lock` falling in the same cycle as `dvi_ok` rising: the lock loss wins.
- A DVI candidate that matures during `S_HOST` stays pending (`stab_cnt` saturated). It is taken on host exit if still stable.
- All arithmetic is unsigned. Counters are 16 bits wide; parameters must fit.

## Timing
- Reset values: `cmd_out` = `DEFAULT_CMD`, `cmd_src` = 0, `cmd_upd` = 0, `host_ack` = 0, `wdt_clr` = 0. All counters are 0, `dvi_q` = 0, state is `S_DEF`.
- Reset asserted mid-operation forces these values immediately (asynchronously). Operation resumes on the first `clkwdt` edge after `rst` deasserts.
- Host latency: `host_req` high at edge N gives `host_ack`, `cmd_out`, `cmd_src` and `cmd_upd` valid after edge N+1.
- DVI latency: the first `cmd_out` change happens `STABLE_TICKS` + 2 cycles after `dvi_cmd` settles with `dvi_lock` high.
- Lock loss: `cmd_out` = `DEFAULT_CMD` one cycle after `dvi_lock` falls.
- Host timeout: exit occurs exactly `HOST_HOLD_TICKS` + 1 cycles after the last accept, absent other events.

## Configuration
- `DVICMD_HOST_EN` defined: host port and `S_HOST` are implemented as above.
- `DVICMD_HOST_EN` undefined:
  - `host_req`, `host_cmd` and `host_rel` are ignored, and `host_ack` is tied 0.
  - `hold_cnt` is removed and `S_HOST` is unreachable.
  - `cmd_src` never equals 2.

## Test plan
- Reset, then `dvi_lock` = 1 with `dvi_cmd` = 16'h1234 constant → `cmd_out` = 16'h1234, `cmd_src` = 1 and one `cmd_upd` at cycle 6002 (6000 + 2). `wdt_clr` toggles on the update, then every 1000 cycles.
- `dvi_cmd` changes every 5000 cycles → `cmd_out` stays at `DEFAULT_CMD`, `cmd_src` = 0, `wdt_clr` never toggles.
- In `S_DVI`, `host_req` with `host_cmd` = 16'hA5A5 → one `host_ack`, `cmd_out` = 16'hA5A5, `cmd_src` = 2. After 20001 cycles it returns to `S_DVI` with 16'h1234.
- In `S_HOST`, `host_req` and `host_rel` in the same cycle → re-accept and the hold timer reloads. A later `host_rel` alone returns to `S_DEF` if `dvi_lock` = 0.
- `dvi_lock` dropped in `S_DVI`, and separately `rst` asserted mid-hold → `cmd_out` = 0 and `cmd_src` = 0 in both cases. The first gives one cycle of latency; the second is immediate.
- Without `DVICMD_HOST_EN`, `host_req` = 1 → `host_ack` stays 0 and `cmd_src` is never 2.

Source files
------------

// File: rtl/dvicmd_sched.sv
// LED-panel DVI command scheduler: arbitrates DVI / host / default command sources and drives the wdt_clr heartbeat.
// Optional host port and S_HOST ownership are built only when DVICMD_HOST_EN is defined.
module dvicmd_sched #(
  parameter int unsigned      CMD_W           = 16,
  parameter int unsigned      STABLE_TICKS    = 6000,
  parameter int unsigned      HOST_HOLD_TICKS = 20000,
  parameter int unsigned      HB_TICKS        = 1000,
  parameter logic [CMD_W-1:0] DEFAULT_CMD     = '0
) (
  input  logic             clkwdt,
  input  logic             rst,
  input  logic [CMD_W-1:0] dvi_cmd,
  input  logic             dvi_lock,
  input  logic             host_req,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             host_rel,
  output logic             host_ack,
  output logic [CMD_W-1:0] cmd_out,
  output logic [1:0]       cmd_src,
  output logic             cmd_upd,
  output logic             wdt_clr
);

  typedef enum logic [1:0] {
    S_DEF  = 2'd0,
    S_DVI  = 2'd1,
    S_HOST = 2'd2
  } state_e;

  localparam logic [15:0] STAB_MAX = 16'(STABLE_TICKS);
  localparam logic [15:0] HB_LAST  = 16'(HB_TICKS - 1);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] dvi_q, dvi_d;
  logic [15:0]      stab_q, stab_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             upd_q, upd_d;
  logic             wdt_q, wdt_d;
  logic [15:0]      hb_q, hb_d;

  logic             dvi_ok_s;
  logic             host_acc_s;
  logic             host_exit_s;
  logic [CMD_W-1:0] host_cmd_s;

`ifdef DVICMD_HOST_EN
  localparam logic [15:0] HOLD_INIT = 16'(HOST_HOLD_TICKS);

  logic        ack_q, ack_d;
  logic [15:0] hold_q, hold_d;

  // A request seen in the cycle right after an ack is the tail of the same handshake.
  assign host_acc_s  = host_req & ~ack_q;
  assign host_exit_s = host_rel | (hold_q == 16'd0);
  assign host_cmd_s  = host_cmd;
  assign host_ack    = ack_q;

  always_comb begin
    ack_d  = host_acc_s;
    hold_d = hold_q;
    if (host_acc_s) begin
      hold_d = HOLD_INIT;
    end else if ((state_q == S_HOST) && (hold_q != 16'd0)) begin
      hold_d = hold_q - 16'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clkwdt or negedge rst) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      hold_q <= 16'd0;
    end else begin
      ack_q  <= ack_d;
      hold_q <= hold_d;
    end
  end
`else
  logic unused_host_s;

  assign host_acc_s    = 1'b0;
  assign host_exit_s   = 1'b1;
  assign host_cmd_s    = DEFAULT_CMD;
  assign host_ack      = 1'b0;
  assign unused_host_s = ^{host_req, host_cmd, host_rel};
`endif

  // Stability filter: count consecutive identical samples while the link is locked.
  always_comb begin
    dvi_d = dvi_cmd;
    if (!dvi_lock || (dvi_cmd != dvi_q)) begin
      stab_d = 16'd0;
    end else if (stab_q == STAB_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 16'd1;
    end
  end

  assign dvi_ok_s = (stab_q == STAB_MAX) & dvi_lock;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DEF: begin
        if (host_acc_s)    state_d = S_HOST;
        else if (dvi_ok_s) state_d = S_DVI;
        else               state_d = S_DEF;
      end
      S_DVI: begin
        if (host_acc_s)     state_d = S_HOST;
        else if (!dvi_lock) state_d = S_DEF;
        else                state_d = S_DVI;
      end
      S_HOST: begin
        if (host_acc_s)       state_d = S_HOST;
        else if (host_exit_s) state_d = dvi_ok_s ? S_DVI : S_DEF;
        else                  state_d = S_HOST;
      end
      default: state_d = S_DEF;
    endcase
  end

  always_comb begin
    cmd_d = cmd_q;
    case (state_q)
      S_DEF: begin
        if (host_acc_s)    cmd_d = host_cmd_s;
        else if (dvi_ok_s) cmd_d = dvi_q;
        else               cmd_d = cmd_q;
      end
      S_DVI: begin
        if (host_acc_s)                         cmd_d = host_cmd_s;
        else if (!dvi_lock)                     cmd_d = DEFAULT_CMD;
        else if (dvi_ok_s && (dvi_q != cmd_q))  cmd_d = dvi_q;
        else                                    cmd_d = cmd_q;
      end
      S_HOST: begin
        if (host_acc_s)       cmd_d = host_cmd_s;
        else if (host_exit_s) cmd_d = dvi_ok_s ? dvi_q : DEFAULT_CMD;
        else                  cmd_d = cmd_q;
      end
      default: cmd_d = DEFAULT_CMD;
    endcase
  end

  // Heartbeat only free-runs while a live source owns the output, so dot_wdt can expire in S_DEF.
  always_comb begin
    upd_d = (cmd_d != cmd_q);
    wdt_d = wdt_q;
    hb_d  = hb_q;
    if (upd_d || ((state_q != S_DEF) && (hb_q == HB_LAST))) begin
      wdt_d = ~wdt_q;
      hb_d  = 16'd0;
    end else if (state_q != S_DEF) begin
      wdt_d = wdt_q;
      hb_d  = hb_q + 16'd1;
    end else begin
      wdt_d = wdt_q;
      hb_d  = 16'd0;
    end
  end

  always_ff @(posedge clkwdt or negedge rst) begin
    if (!rst) begin
      state_q <= S_DEF;
      dvi_q   <= '0;
      stab_q  <= 16'd0;
      cmd_q   <= DEFAULT_CMD;
      upd_q   <= 1'b0;
      wdt_q   <= 1'b0;
      hb_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      dvi_q   <= dvi_d;
      stab_q  <= stab_d;
      cmd_q   <= cmd_d;
      upd_q   <= upd_d;
      wdt_q   <= wdt_d;
      hb_q    <= hb_d;
    end
  end

  assign cmd_out = cmd_q;
  assign cmd_src = state_q;
  assign cmd_upd = upd_q;
  assign wdt_clr = wdt_q;

endmodule

// File: tb/tb_dvicmd_sched.sv
// Directed bench for dvicmd_sched with shortened timing parameters; host checks follow DVICMD_HOST_EN.
module tb_dvicmd_sched;

  localparam logic [15:0] DEF = 16'h00C3;

  logic        clkwdt;
  logic        rst;
  logic [15:0] dvi_cmd;
  logic        dvi_lock;
  logic        host_req;
  logic [15:0] host_cmd;
  logic        host_rel;
  logic        host_ack;
  logic [15:0] cmd_out;
  logic [1:0]  cmd_src;
  logic        cmd_upd;
  logic        wdt_clr;

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int ack_cnt = 0;
  logic src2_seen = 1'b0;
  int upd_base;
  int ack_base;

  dvicmd_sched #(
    .CMD_W          (16),
    .STABLE_TICKS   (6),
    .HOST_HOLD_TICKS(20),
    .HB_TICKS       (10),
    .DEFAULT_CMD    (DEF)
  ) dut (
    .clkwdt  (clkwdt),
    .rst     (rst),
    .dvi_cmd (dvi_cmd),
    .dvi_lock(dvi_lock),
    .host_req(host_req),
    .host_cmd(host_cmd),
    .host_rel(host_rel),
    .host_ack(host_ack),
    .cmd_out (cmd_out),
    .cmd_src (cmd_src),
    .cmd_upd (cmd_upd),
    .wdt_clr (wdt_clr)
  );

  initial clkwdt = 1'b0;
  always #5 clkwdt = ~clkwdt;

  // Event tallies sampled shortly after each active edge
  always @(posedge clkwdt) begin
    #2;
    if (cmd_upd === 1'b1) upd_cnt++;
    if (host_ack === 1'b1) ack_cnt++;
    if (cmd_src === 2'd2) src2_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clkwdt);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; dvi_cmd = 16'h0000; dvi_lock = 1'b0;
    host_req = 1'b0; host_cmd = 16'h0000; host_rel = 1'b0;
    tick(2);
    chk("rst_cmd", cmd_out, DEF);
    chk("rst_src", cmd_src, 2'd0);
    chk("rst_upd", cmd_upd, 1'b0);
    chk("rst_ack", host_ack, 1'b0);
    chk("rst_wdt", wdt_clr, 1'b0);

    // DVI acceptance after STABLE_TICKS+2 edges
    rst = 1'b1; dvi_lock = 1'b1; dvi_cmd = 16'h1234;
    tick(7);
    chk("dvi_pre_cmd", cmd_out, DEF);
    chk("dvi_pre_src", cmd_src, 2'd0);
    tick(1);
    chk("dvi_acc_cmd", cmd_out, 16'h1234);
    chk("dvi_acc_src", cmd_src, 2'd1);
    chk("dvi_acc_upd", cmd_upd, 1'b1);
    chk("dvi_acc_wdt", wdt_clr, 1'b1);
    upd_base = upd_cnt;
    tick(9);
    chk("hb_hold_wdt", wdt_clr, 1'b1);
    chk("hb_hold_upd", cmd_upd, 1'b0);
    tick(1);
    chk("hb_tog1_wdt", wdt_clr, 1'b0);
    tick(10);
    chk("hb_tog2_wdt", wdt_clr, 1'b1);
    chk("steady_no_upd", upd_cnt - upd_base, 0);

    // New DVI value while in S_DVI
    dvi_cmd = 16'h5678;
    tick(7);
    chk("dvi_chg_pre", cmd_out, 16'h1234);
    chk("dvi_chg_pre_wdt", wdt_clr, 1'b1);
    tick(1);
    chk("dvi_chg_cmd", cmd_out, 16'h5678);
    chk("dvi_chg_upd", cmd_upd, 1'b1);
    chk("dvi_chg_wdt", wdt_clr, 1'b0);
    tick(9);
    chk("hb_tog3_pre", wdt_clr, 1'b0);
    tick(1);
    chk("hb_tog3_wdt", wdt_clr, 1'b1);

    // Lock loss: default one cycle later, heartbeat frozen
    dvi_lock = 1'b0;
    tick(1);
    chk("lock_loss_cmd", cmd_out, DEF);
    chk("lock_loss_src", cmd_src, 2'd0);
    chk("lock_loss_upd", cmd_upd, 1'b1);
    chk("lock_loss_wdt", wdt_clr, 1'b0);
    upd_base = upd_cnt;
    tick(30);
    chk("def_wdt_frozen", wdt_clr, 1'b0);

    // Unstable DVI: changes every STABLE_TICKS cycles never mature
    dvi_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dvi_cmd = 16'h1000 + 16'(i);
      tick(6);
    end
    chk("unstable_cmd", cmd_out, DEF);
    chk("unstable_src", cmd_src, 2'd0);
    chk("unstable_wdt", wdt_clr, 1'b0);
    chk("unstable_no_upd", upd_cnt - upd_base, 0);

    // Lock drops in the cycle dvi_ok would rise
    dvi_cmd = 16'h2222;
    tick(7);
    chk("race_pre_cmd", cmd_out, DEF);
    dvi_lock = 1'b0;
    tick(1);
    chk("race_cmd", cmd_out, DEF);
    chk("race_src", cmd_src, 2'd0);
    dvi_lock = 1'b1;
    tick(6);
    chk("relock_pre", cmd_out, DEF);
    tick(1);
    chk("relock_cmd", cmd_out, 16'h2222);
    chk("relock_src", cmd_src, 2'd1);
    chk("relock_wdt", wdt_clr, 1'b1);

`ifdef DVICMD_HOST_EN
    ack_base = ack_cnt;
    host_cmd = 16'hA5A5; host_req = 1'b1;
    tick(1);
    chk("host_acc_ack", host_ack, 1'b1);
    chk("host_acc_cmd", cmd_out, 16'hA5A5);
    chk("host_acc_src", cmd_src, 2'd2);
    chk("host_acc_upd", cmd_upd, 1'b1);
    tick(1);
    chk("host_noreacc_ack", host_ack, 1'b0);
    chk("host_noreacc_cmd", cmd_out, 16'hA5A5);
    host_req = 1'b0;
    tick(19);
    chk("hold_last_src", cmd_src, 2'd2);
    tick(1);
    chk("hold_exit_src", cmd_src, 2'd1);
    chk("hold_exit_cmd", cmd_out, 16'h2222);
    chk("hold_exit_upd", cmd_upd, 1'b1);

    host_cmd = 16'hBEEF; host_req = 1'b1;
    tick(1);
    chk("host2_cmd", cmd_out, 16'hBEEF);
    host_req = 1'b0;
    tick(5);
    host_cmd = 16'hCAFE; host_req = 1'b1; host_rel = 1'b1;
    tick(1);
    chk("reacc_ack", host_ack, 1'b1);
    chk("reacc_cmd", cmd_out, 16'hCAFE);
    chk("reacc_src", cmd_src, 2'd2);
    host_req = 1'b0; host_rel = 1'b0;
    tick(16);
    chk("reload_src", cmd_src, 2'd2);
    dvi_lock = 1'b0; host_rel = 1'b1;
    tick(1);
    chk("rel_src", cmd_src, 2'd0);
    chk("rel_cmd", cmd_out, DEF);
    chk("rel_upd", cmd_upd, 1'b1);
    chk("host_ack_count", ack_cnt - ack_base, 3);
    chk("src2_seen", src2_seen, 1'b1);
    host_rel = 1'b0; dvi_lock = 1'b1;
    host_cmd = 16'h1111; host_req = 1'b1;
    tick(1);
    chk("host3_src", cmd_src, 2'd2);
    host_req = 1'b0;
    tick(3);
`else
    ack_base = ack_cnt;
    upd_base = upd_cnt;
    host_cmd = 16'hA5A5; host_req = 1'b1; host_rel = 1'b1;
    tick(1);
    host_rel = 1'b0;
    tick(29);
    chk("nohost_ack_count", ack_cnt - ack_base, 0);
    chk("nohost_src2", src2_seen, 1'b0);
    chk("nohost_src", cmd_src, 2'd1);
    chk("nohost_cmd", cmd_out, 16'h2222);
    chk("nohost_no_upd", upd_cnt - upd_base, 0);
    host_req = 1'b0;
`endif

    // Asynchronous reset mid-operation
    #2 rst = 1'b0;
    #1;
    chk("arst_cmd", cmd_out, DEF);
    chk("arst_src", cmd_src, 2'd0);
    chk("arst_ack", host_ack, 1'b0);
    chk("arst_upd", cmd_upd, 1'b0);
    chk("arst_wdt", wdt_clr, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(7);
    chk("resume_pre", cmd_out, DEF);
    tick(1);
    chk("resume_cmd", cmd_out, 16'h2222);
    chk("resume_src", cmd_src, 2'd1);
    chk("resume_wdt", wdt_clr, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
